// File: rtl/apb_spi_xip_reader.sv
// apb_spi_xip_reader: APB read window onto SPI NOR flash using native READ (0x03).
// Define XIP_LINE_BUF_EN to add a single-line multi-word read buffer.
module apb_spi_xip_reader #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter int ADDR_BITS  = 24,
    parameter int CLK_DIV    = 1,
    parameter int SS_NUM     = 8,
    parameter int SS_IDX     = 0,
    parameter int LINE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [2:0]        in_pprot,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    input  logic              xip_flush,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);
`ifdef XIP_LINE_BUF_EN
    localparam int W = LINE_WORDS;
`else
    localparam int W = 1;
    localparam int unused_line_words = LINE_WORDS;
`endif
    localparam int TXW = 8 + ADDR_BITS;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [ADDR_BITS-1:0] AMASK = ~ADDR_BITS'(4 * W - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, RESP} state_t;
    state_t state, state_nx;

    logic [DW-1:0]        div_cnt;
    logic [5:0]           bit_cnt;
    logic [3:0]           word_cnt;
    logic [3:0]           widx;
    logic [TXW-1:0]       tx_sr;
    logic [31:0]          rx_sr;
    logic [31:0]          rdata;
    logic                 sck_q;
    logic                 ss_q;
    logic                 tail;

    logic                 access;
    logic                 in_range;
    logic                 err;
    logic                 hit;
    logic                 start;
    logic                 busy;
    logic                 half;
    logic                 rise;
    logic                 fall;
    logic                 seg_last;
    logic                 word_end;
    logic [ADDR_BITS-1:0] line_addr;
    logic [31:0]          rx_word;
    logic [31:0]          hit_word;

    assign access    = in_psel && in_penable && state == IDLE;
    assign in_range  = (64'(in_paddr) >> ADDR_BITS) == (64'(FLASH_BASE) >> ADDR_BITS);
    assign err       = access && (in_pwrite || !in_range);
    assign start     = access && !err && !hit;
    assign line_addr = in_paddr[ADDR_BITS-1:0] & AMASK;
    assign busy      = state == CMD || state == ADDR || state == DATA;
    assign half      = div_cnt == DW'(CLK_DIV - 1);
    assign rise      = busy && !tail && !sck_q && half;
    assign fall      = busy && !tail && sck_q && half;
    assign word_end  = state == DATA && fall && seg_last;
    // first flash byte of a word lands in its least significant byte
    assign rx_word   = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};

    always_comb begin
        seg_last = 1'b0;
        unique case (state)
            CMD:     seg_last = bit_cnt == 6'd7;
            ADDR:    seg_last = bit_cnt == 6'(ADDR_BITS - 1);
            DATA:    seg_last = bit_cnt == 6'd31;
            default: seg_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (access && !err) state_nx = hit ? RESP : CMD;
            CMD:     if (fall && seg_last) state_nx = ADDR;
            ADDR:    if (fall && seg_last) state_nx = DATA;
            DATA:    if (tail) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_pready  = err || (state == RESP && in_psel);
    assign in_pslverr = err;
    assign in_prdata  = (state == RESP && in_psel) ? rdata : 32'd0;
    assign spi_sck    = sck_q;
    assign spi_mosi   = tx_sr[TXW-1];
    assign spi_ss     = ~(SS_NUM'(!ss_q) << SS_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            widx     <= '0;
            tx_sr    <= '1;
            rx_sr    <= '0;
            rdata    <= '0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            tail     <= 1'b0;
        end else begin
            state <= state_nx;
            if (hit) rdata <= hit_word;
            if (start) begin
                tx_sr    <= {8'h03, line_addr};
                ss_q     <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
                tail     <= 1'b0;
                widx     <= in_paddr[5:2] & 4'(W - 1);
            end else if (busy && !tail) begin
                div_cnt <= half ? '0 : div_cnt + 1'b1;
                if (half) sck_q <= !sck_q;
                if (rise) rx_sr <= {rx_sr[30:0], spi_miso};
                if (fall) begin
                    tx_sr   <= {tx_sr[TXW-2:0], 1'b1};
                    bit_cnt <= seg_last ? '0 : bit_cnt + 1'b1;
                end
                if (word_end) begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == widx) rdata <= rx_word;
                    if (word_cnt == 4'(W - 1)) tail <= 1'b1;
                end
            end else if (tail) begin
                // one SCK-low cycle after the last fall, then release CS
                ss_q <= 1'b1;
                tail <= 1'b0;
            end
        end
    end

`ifdef XIP_LINE_BUF_EN
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    logic [W-1:0][31:0]   line_q;
    logic [ADDR_BITS-1:0] tag_q;
    logic                 valid_q;
    logic                 flushed;
    logic                 unused_ok;

    assign hit = access && !err && valid_q && tag_q == line_addr && !xip_flush;
    assign hit_word = line_q[IW'(in_paddr[5:2] & 4'(W - 1))];
    assign unused_ok = ^{in_pprot, in_pwdata, in_pstrb};

    always_ff @(posedge clock) begin
        if (reset) begin
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            flushed <= 1'b0;
        end else begin
            if (start) begin
                tag_q   <= line_addr;
                valid_q <= 1'b0;
                flushed <= 1'b0;
            end
            if (word_end) line_q[IW'(word_cnt)] <= rx_word;
            if (state == DATA && tail) valid_q <= !flushed && !xip_flush;
            if (xip_flush) begin
                valid_q <= 1'b0;
                if (busy) flushed <= 1'b1;
            end
        end
    end
`else
    logic unused_ok;

    assign hit = 1'b0;
    assign hit_word = '0;
    assign unused_ok = ^{in_pprot, in_pwdata, in_pstrb, xip_flush};
`endif

endmodule

// File: tb/tb_apb_spi_xip_reader.sv
// tb_apb_spi_xip_reader: random APB reads against a flash model and a line-buffer model.
// Builds with or without XIP_LINE_BUF_EN.
module tb_apb_spi_xip_reader;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int AB = 24;
    localparam int CD = 1;
`ifdef XIP_LINE_BUF_EN
    localparam int W = 4;
    localparam bit BUF = 1'b1;
`else
    localparam int W = 1;
    localparam bit BUF = 1'b0;
`endif
    localparam int HB = 8 + AB;
    localparam int NB = HB + 32 * W;

    logic        clock;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic        in_pwrite;
    logic [2:0]  in_pprot;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        xip_flush;
    logic        spi_sck;
    logic [7:0]  spi_ss;
    logic        spi_mosi;
    logic        spi_miso;

    apb_spi_xip_reader dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_penable (in_penable),
        .in_pwrite  (in_pwrite),
        .in_pprot   (in_pprot),
        .in_pwdata  (in_pwdata),
        .in_pstrb   (in_pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .xip_flush  (xip_flush),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fb(input logic [31:0] a);
        case (a)
            32'h104: return 8'h11;
            32'h105: return 8'h22;
            32'h106: return 8'h33;
            32'h107: return 8'h44;
            default: return 8'(a * 37 + (a >> 8) * 11 + 32'h5A);
        endcase
    endfunction

    function automatic logic fbit(input logic [31:0] base, input int k);
        logic [7:0] b;
        b = fb(base + 32'(k / 8));
        return b[7 - (k % 8)];
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] off);
        logic [31:0] o;
        o = off & ~32'd3;
        return {fb(o + 3), fb(o + 2), fb(o + 1), fb(o)};
    endfunction

    // flash slave: frames start at CS fall, header captured on SCK rises
    int            rises_total = 0;
    int            ss_low_total = 0;
    int            fr_bits = 0;
    int            ss_fall_cyc = 0;
    int            first_rise_cyc = 0;
    logic [HB-1:0] fr_hdr = '0;
    logic          prev_sck = 1'b0;
    logic          prev_ss = 1'b1;

    always @(negedge clock) begin
        if (!spi_ss[0]) ss_low_total++;
        if (prev_ss && !spi_ss[0]) begin
            fr_bits = 0;
            fr_hdr = '0;
            ss_fall_cyc = cyc;
        end
        if (!spi_ss[0] && spi_sck && !prev_sck) begin
            if (fr_bits == 0) first_rise_cyc = cyc;
            rises_total++;
            if (fr_bits < HB) fr_hdr = {fr_hdr[HB-2:0], spi_mosi};
            fr_bits++;
        end
        if (!spi_ss[0] && !spi_sck && fr_bits >= HB)
            spi_miso = fbit(32'(fr_hdr[AB-1:0]), fr_bits - HB);
        else
            spi_miso = 1'b0;
        prev_sck = spi_sck;
        prev_ss = spi_ss[0];
    end

    always @(posedge clock) cyc++;

    bit          m_valid = 1'b0;
    logic [31:0] m_tag = '0;

    // fl_cyc: -1 none, -2 random inside the access, else offset from cycle A
    task automatic xfer(input logic [31:0] addr, input bit wr, input int fl_cyc);
        bit          in_win;
        bit          hit;
        bit          miss;
        bit          got;
        bit          err;
        int          lat;
        int          exp_lat;
        int          r0;
        int          s0;
        int          a_cyc;
        int          fl;
        logic [31:0] off;
        logic [31:0] line;
        logic [31:0] data;
        logic [7:0]  ss_resp;
        in_win = (addr >> AB) == (BASE >> AB);
        off = addr & ((32'd1 << AB) - 1);
        line = off & ~(32'(4 * W) - 1);
        fl = fl_cyc;
        hit = BUF && !wr && in_win && m_valid && m_tag == line && fl != 0;
        miss = !wr && in_win && !hit;
        exp_lat = (wr || !in_win) ? 0 : hit ? 1 : 2 + 2 * NB * CD;
        if (fl == -2) fl = (exp_lat > 0) ? int'($urandom_range(1, exp_lat)) : -1;
        r0 = rises_total;
        s0 = ss_low_total;
        got = 1'b0;
        lat = 0;
        a_cyc = 0;
        data = '0;
        err = 1'b0;
        ss_resp = '0;
        @(posedge clock);
        #1;
        in_psel = 1'b1;
        in_pwrite = wr;
        in_paddr = addr;
        in_penable = 1'b0;
        in_pwdata = $urandom;
        @(posedge clock);
        #1;
        in_penable = 1'b1;
        xip_flush = (fl == 0);
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clock);
            if (i == 0) a_cyc = cyc;
            if (in_pready) begin
                got = 1'b1;
                lat = i;
                data = in_prdata;
                err = in_pslverr;
                ss_resp = spi_ss;
            end
            @(posedge clock);
            #1;
            xip_flush = (i + 1 == fl);
        end
        xip_flush = 1'b0;
        in_psel = 1'b0;
        in_penable = 1'b0;
        in_pwrite = 1'b0;
        chk("pready_seen", 64'(got), 64'd1);
        if (got) begin
            chk("latency", 64'(lat), 64'(exp_lat));
            chk("pslverr", 64'(err), 64'(wr || !in_win));
            chk("prdata", 64'(data), (wr || !in_win) ? 64'd0 : 64'(exp_word(off)));
            chk("ss_at_resp", 64'(ss_resp), 64'hFF);
        end
        chk("sck_rises", 64'(rises_total - r0), miss ? 64'(NB) : 64'd0);
        if (miss) begin
            chk("hdr", 64'(fr_hdr), 64'({8'h03, line[AB-1:0]}));
            chk("ss_fall", 64'(ss_fall_cyc - a_cyc), 64'd1);
            chk("first_rise", 64'(first_rise_cyc - a_cyc), 64'(1 + CD));
        end else begin
            chk("ss_idle", 64'(ss_low_total - s0), 64'd0);
        end
        if (fl >= 0 && fl <= exp_lat) m_valid = 1'b0;
        else if (miss) begin
            m_valid = BUF;
            m_tag = line;
        end
    endtask

    task automatic reset_mid(input logic [31:0] addr);
        bit reached;
        reached = 1'b0;
        @(posedge clock);
        #1;
        in_psel = 1'b1;
        in_pwrite = 1'b0;
        in_paddr = addr;
        in_penable = 1'b0;
        @(posedge clock);
        #1;
        in_penable = 1'b1;
        for (int i = 0; i < 1000 && !reached; i++) begin
            @(negedge clock);
            if (!spi_ss[0] && fr_bits == HB - AB + 20) reached = 1'b1;
        end
        chk("rst_reach", 64'(reached), 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_psel = 1'b0;
        in_penable = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_ss", 64'(spi_ss), 64'hFF);
        chk("rst_sck", 64'(spi_sck), 64'd0);
        chk("rst_pready", 64'(in_pready), 64'd0);
        reset = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1;
        in_paddr = '0;
        in_psel = 1'b0;
        in_penable = 1'b0;
        in_pwrite = 1'b0;
        in_pprot = '0;
        in_pwdata = '0;
        in_pstrb = 4'hF;
        xip_flush = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_ss", 64'(spi_ss), 64'hFF);
            chk("idle_sck", 64'(spi_sck), 64'd0);
            chk("idle_mosi", 64'(spi_mosi), 64'd1);
            chk("idle_pready", 64'(in_pready), 64'd0);
        end
        chk("rst_prdata", 64'(in_prdata), 64'd0);
        chk("rst_pslverr", 64'(in_pslverr), 64'd0);

        xfer(BASE + 32'h104, 1'b0, -1);
        xfer(BASE + 32'h108, 1'b0, -1);
        xfer(BASE + 32'h10C, 1'b0, -1);
        xfer(BASE, 1'b1, -1);
        xfer(32'h4000_0000, 1'b0, -1);
        xfer(BASE + (32'd1 << AB), 1'b0, -1);
        xfer(BASE + (32'd1 << AB) - 4, 1'b0, -1);

        xfer(BASE + 32'h100, 1'b0, 40);
        xfer(BASE + 32'h100, 1'b0, -1);
        xfer(BASE + 32'h104, 1'b0, -1);
        xfer(BASE + 32'h100, 1'b0, 0);
        xfer(BASE + 32'h200, 1'b0, -1);

        reset_mid(BASE + 32'h100);
        xfer(BASE + 32'h100, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                xfer(BASE + 32'($urandom_range(0, 32'hFFF)), 1'b1, -1);
            end else if (r == 1) begin
                a = $urandom;
                if (a[31:24] == BASE[31:24]) a[31] = ~a[31];
                xfer(a, 1'b0, -1);
            end else begin
                a = BASE + 32'($urandom_range(32'h100, 32'h13F));
                xfer(a, 1'b0, ($urandom_range(0, 5) == 0) ? -2 : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
